hazard_forward_unit: RTL and testbench
======================================

Name: hazard_forward_unit

Overview:
- Pipeline control block that drives the execute stage's forwardA/forwardB selects and the load-use stall/bubble.
- Sits beside the ID/EX, EX/MEM and MEM/WB registers.
- Keeps its own shadow pipeline of destination tags (rd, RegWrite, MemRead, valid) for the EX, MEM and WB slots.
- At each ID→EX advance it computes registered forward selects, so they are stable for the whole EX cycle.

Parameters:
- REG_W, 5, register index width.
- ZERO_REG, 31, XZR index; never a forwarding source.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high
- id_valid  input  1  ID slot holds a real instruction
- id_rn  input  REG_W  first source register of ID instruction
- id_rm  input  REG_W  second source register (Rm, or Rt for STUR/CBZ)
- id_uses_rn  input  1  ID instruction reads Rn
- id_uses_rm  input  1  ID instruction reads Rm through the ALU B path (0 when the immediate/DT path is selected)
- id_rd  input  REG_W  destination of ID instruction
- id_reg_write  input  1  ID instruction writes rd
- id_mem_read  input  1  ID instruction is a load (LDUR)
- flush  input  1  branch taken; kill the ID instruction
- forwardA  output  2  EX operand A select
- forwardB  output  2  EX operand B select
- stall  output  1  hold PC and IF/ID this cycle
- stall_count  output  CNT_W  saturating count of load-use stalls

Behaviour:
- Select encoding for both forwardA and forwardB:
  - 2'b00 = register file value.
  - 2'b01 = WB-stage writeback value.
  - 2'b10 = MEM-stage ALU result.
  - 2'b11 is never driven.
- Shadow tags ex_t, mem_t, wb_t each hold {valid, rd, reg_write, mem_read}.
- Every edge: wb_t<=mem_t; mem_t<=ex_t.
- ex_t update at each edge:
  - When stall=0 and flush=0: ex_t<=ID fields, with valid=id_valid.
  - When stall=1 or flush=1: ex_t<=bubble (all fields 0).
- Definition: a slot tag T "writes r" iff T.valid & T.reg_write & T.rd==r & r!=ZERO_REG.
- stall (combinational):
  - Asserted when id_valid & ex_t.valid & ex_t.mem_read & ex_t.reg_write & ex_t.rd!=ZERO_REG.
  - And additionally when either (id_uses_rn & id_rn==ex_t.rd) or (id_uses_rm & id_rm==ex_t.rd).
  - flush=1 forces stall=0.
- Stall length is exactly one cycle: after the edge, the load has moved to MEM and a bubble is in EX, so stall deasserts. The consumer then enters EX with forward 01 (load data from WB).
- Next forwardA, registered at each edge:
  - stall=1 or flush=1 or !id_valid or !id_uses_rn → 00.
  - else if ex_t writes id_rn and !ex_t.mem_read → 10 (nearest producer wins).
  - else if mem_t writes id_rn → 01.
  - else 00.
- Next forwardB: same rule with id_rm and id_uses_rm.
- A load in ex_t is never a 10 source: that case is always covered by stall.
- Distance-3 producers (producer in WB while consumer is in ID) are not handled here; the register file is write-first.
- stall_count increments on each cycle with stall=1 and saturates at all-ones.
- Reset (async, any time including mid-stall):
  - All tags → bubble.
  - forwardA=forwardB=00, stall=0, stall_count=0.
- No combinational path from the forward outputs back to the ID inputs.

Decomposition:
- Shared package cpu_pkg:
  - typedef fwd_sel_t (2-bit) with FWD_REG, FWD_WB, FWD_MEM.
  - struct stage_tag_t {valid, rd, reg_write, mem_read}.
  - Constant XZR=31.
- One natural sub-module: fwd_select. It is combinational: two tags plus a source register and use bit in, fwd_sel_t out, instantiated for A and B.

Test Plan:
- ADD X1,X2,X3 then ADD X4,X1,X5 back-to-back → in the consumer's EX cycle forwardA=10, forwardB=00, stall=0.
- ADD X1,.. ; unrelated op ; SUB X6,X7,X1 (uses_rm=1) → forwardB=01 in SUB's EX cycle.
- Producers X1 at distance 1 and 2, consumer reads X1 → forwardA=10, since MEM priority beats WB.
- LDUR X2,[X0] then ADD X3,X2,X2:
  - stall=1 for exactly one cycle and a bubble appears in EX.
  - Next cycle forwardA=forwardB=01.
  - stall_count goes 0→1.
- Producer writes X31, or id_uses_rm=0 (immediate) → forward stays 00. flush=1 during a load-use hazard → stall=0 and ex_t becomes a bubble.
- Assert reset mid-stall → stall, forwardA, forwardB and stall_count all 0 immediately (asynchronously); a dependent pair after reset forwards correctly.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline-control types: forward select encoding, per-slot destination tag
// and the zero-register index.
package cpu_pkg;

  localparam int TAG_RD_W = 5;
  localparam int XZR      = 31;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_RD_W-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } stage_tag_t;

  localparam stage_tag_t TAG_BUBBLE = '0;

  // The zero register is never a real destination, so it never matches.
  function automatic logic tag_writes(input logic                valid,
                                      input logic                reg_write,
                                      input logic [TAG_RD_W-1:0] rd,
                                      input logic [TAG_RD_W-1:0] r,
                                      input logic [TAG_RD_W-1:0] zero_reg);
    return valid & reg_write & (rd == r) & (r != zero_reg);
  endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// ID-stage instruction fields in, EX forward selects / stall / shadow tags out.
interface hazard_forward_unit_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  import cpu_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_rn;
  logic [REG_W-1:0] id_rm;
  logic             id_uses_rn;
  logic             id_uses_rm;
  logic [REG_W-1:0] id_rd;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             flush;
  fwd_sel_t         forwardA;
  fwd_sel_t         forwardB;
  logic             stall;
  logic [CNT_W-1:0] stall_count;
  stage_tag_t       ex_tag;
  stage_tag_t       mem_tag;
  stage_tag_t       wb_tag;

  modport master (
    output id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm,
           id_rd, id_reg_write, id_mem_read, flush,
    input  forwardA, forwardB, stall, stall_count, ex_tag, mem_tag, wb_tag
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm,
           id_rd, id_reg_write, id_mem_read, flush,
    output forwardA, forwardB, stall, stall_count, ex_tag, mem_tag, wb_tag
  );

endinterface

// File: rtl/fwd_select.sv
// Chooses the operand source for one ID source register from the EX and MEM
// producer tags; the nearest non-load producer wins.
module fwd_select
  import cpu_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = XZR
) (
  input  stage_tag_t       i_ex_tag,
  input  stage_tag_t       i_mem_tag,
  input  logic [REG_W-1:0] i_src,
  input  logic             i_use,
  output fwd_sel_t         o_sel
);

  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  logic w_ex_hit;
  logic w_mem_hit;
  logic w_unused_mem_read;

  // A load still in EX has no data yet; that case is resolved by the stall.
  assign w_ex_hit  = i_use & ~i_ex_tag.mem_read &
                     tag_writes(i_ex_tag.valid, i_ex_tag.reg_write, i_ex_tag.rd, i_src, ZR);
  assign w_mem_hit = i_use &
                     tag_writes(i_mem_tag.valid, i_mem_tag.reg_write, i_mem_tag.rd, i_src, ZR);

  assign w_unused_mem_read = i_mem_tag.mem_read;

  always_comb begin
    o_sel = FWD_REG;
    if (w_ex_hit) begin
      o_sel = FWD_MEM;
    end else if (w_mem_hit) begin
      o_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// EX-stage forwarding and load-use stall control, tracking its own shadow copy of
// the EX/MEM/WB destination tags.
module hazard_forward_unit
  import cpu_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = XZR,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  hazard_forward_unit_if.slave  bus
);

  localparam logic [REG_W-1:0] ZR = REG_W'(ZERO_REG);

  stage_tag_t       r_ex;
  stage_tag_t       r_mem;
  stage_tag_t       r_wb;
  fwd_sel_t         r_fwd_a;
  fwd_sel_t         r_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt;

  stage_tag_t w_id_tag;
  fwd_sel_t   w_sel_a;
  fwd_sel_t   w_sel_b;
  logic       w_load_hit;
  logic       w_stall;
  logic       w_advance;

  // Load in EX whose destination the ID instruction reads: hold one cycle.
  assign w_load_hit = (bus.id_uses_rn & tag_writes(r_ex.valid, r_ex.reg_write, r_ex.rd, bus.id_rn, ZR)) |
                      (bus.id_uses_rm & tag_writes(r_ex.valid, r_ex.reg_write, r_ex.rd, bus.id_rm, ZR));
  assign w_stall    = bus.id_valid & r_ex.mem_read & w_load_hit & ~bus.flush;
  assign w_advance  = ~w_stall & ~bus.flush;

  always_comb begin
    w_id_tag           = TAG_BUBBLE;
    w_id_tag.valid     = bus.id_valid;
    w_id_tag.rd        = bus.id_rd;
    w_id_tag.reg_write = bus.id_reg_write;
    w_id_tag.mem_read  = bus.id_mem_read;
  end

  fwd_select #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_fwd_a (
    .i_ex_tag  (r_ex),
    .i_mem_tag (r_mem),
    .i_src     (bus.id_rn),
    .i_use     (bus.id_uses_rn & bus.id_valid & w_advance),
    .o_sel     (w_sel_a)
  );

  fwd_select #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_fwd_b (
    .i_ex_tag  (r_ex),
    .i_mem_tag (r_mem),
    .i_src     (bus.id_rm),
    .i_use     (bus.id_uses_rm & bus.id_valid & w_advance),
    .o_sel     (w_sel_b)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex        <= TAG_BUBBLE;
      r_mem       <= TAG_BUBBLE;
      r_wb        <= TAG_BUBBLE;
      r_fwd_a     <= FWD_REG;
      r_fwd_b     <= FWD_REG;
      r_stall_cnt <= '0;
    end else begin
      r_wb    <= r_mem;
      r_mem   <= r_ex;
      r_ex    <= w_advance ? w_id_tag : TAG_BUBBLE;
      r_fwd_a <= w_sel_a;
      r_fwd_b <= w_sel_b;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign bus.forwardA    = r_fwd_a;
  assign bus.forwardB    = r_fwd_b;
  assign bus.stall       = w_stall;
  assign bus.stall_count = r_stall_cnt;
  assign bus.ex_tag      = r_ex;
  assign bus.mem_tag     = r_mem;
  assign bus.wb_tag      = r_wb;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: an instruction-history model checked every
// cycle, plus hand-computed expectations for the listed hazard scenarios.
`timescale 1ns/1ps
module tb_hazard_forward_unit;
  import cpu_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  hazard_forward_unit_if bus ();

  hazard_forward_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;
  logic last_stall;

  typedef struct {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } ins_t;

  localparam ins_t NOP = '{v: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};

  // In-flight instructions, nearest producer first: slot 0 = EX, 1 = MEM, 2 = WB.
  ins_t inflight [3];
  int   m_fa, m_fb, m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_writes(input ins_t t, input logic [4:0] r);
    return t.v && t.rw && (t.rd == r) && (r != 5'd31);
  endfunction

  function automatic logic m_stall();
    ins_t p;
    p = inflight[0];
    if (bus.flush || !bus.id_valid || !p.v || !p.mr) return 1'b0;
    return (bus.id_uses_rn && m_writes(p, bus.id_rn)) ||
           (bus.id_uses_rm && m_writes(p, bus.id_rm));
  endfunction

  // Distance 1 producer comes from MEM next cycle (2), distance 2 from WB (1).
  function automatic int m_fwd(input logic [4:0] r, input logic u);
    if (!u || !bus.id_valid || bus.flush || m_stall()) return 0;
    for (int d = 0; d < 2; d++)
      if (m_writes(inflight[d], r)) return (d == 0) ? 2 : 1;
    return 0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) inflight[k] <= NOP;
      m_fa  <= 0;
      m_fb  <= 0;
      m_cnt <= 0;
    end else begin
      inflight[2] <= inflight[1];
      inflight[1] <= inflight[0];
      if (m_stall() || bus.flush)
        inflight[0] <= NOP;
      else
        inflight[0] <= '{v: bus.id_valid, rd: bus.id_rd, rw: bus.id_reg_write, mr: bus.id_mem_read};
      m_fa <= m_fwd(bus.id_rn, bus.id_uses_rn);
      m_fb <= m_fwd(bus.id_rm, bus.id_uses_rm);
      if (m_stall() && m_cnt < 65535) m_cnt <= m_cnt + 1;
    end
  end

  function automatic logic [7:0] pack_tag(input ins_t t);
    if (!t.v) return 8'h00;
    return {t.v, t.rd, t.rw, t.mr};
  endfunction

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("model_forwardA", 32'(bus.forwardA), 32'(m_fa));
      chk("model_forwardB", 32'(bus.forwardB), 32'(m_fb));
      chk("model_stall", 32'(bus.stall), 32'(m_stall()));
      chk("model_stall_count", 32'(bus.stall_count), 32'(m_cnt));
      chk("model_ex_tag", 32'(bus.ex_tag), 32'(pack_tag(inflight[0])));
      chk("model_mem_tag", 32'(bus.mem_tag), 32'(pack_tag(inflight[1])));
      chk("model_wb_tag", 32'(bus.wb_tag), 32'(pack_tag(inflight[2])));
    end
  end

  task automatic set_id(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                        input logic urn, input logic urm, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic fl);
    bus.id_valid     = v;
    bus.id_rn        = rn;
    bus.id_rm        = rm;
    bus.id_uses_rn   = urn;
    bus.id_uses_rm   = urm;
    bus.id_rd        = rd;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
    bus.flush        = fl;
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic issue(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                       input logic urn, input logic urm, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic fl);
    set_id(v, rn, rm, urn, urm, rd, rw, mr, fl);
    #2 last_stall = bus.stall;
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_forwardA", 32'(bus.forwardA), 0);
    chk("reset_forwardB", 32'(bus.forwardB), 0);
    chk("reset_stall", 32'(bus.stall), 0);
    chk("reset_stall_count", 32'(bus.stall_count), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // ADD X1,X2,X3 ; ADD X4,X1,X5
    issue(1, 5'd2, 5'd3, 1, 1, 5'd1, 1, 0, 0);
    issue(1, 5'd1, 5'd5, 1, 1, 5'd4, 1, 0, 0);
    chk("dist1_forwardA", 32'(bus.forwardA), 2);
    chk("dist1_forwardB", 32'(bus.forwardB), 0);
    chk("dist1_stall", 32'(last_stall), 0);

    // ADD X1 ; ADD X9,X10,X11 ; SUB X6,X7,X1
    issue(1, 5'd2, 5'd3, 1, 1, 5'd1, 1, 0, 0);
    issue(1, 5'd10, 5'd11, 1, 1, 5'd9, 1, 0, 0);
    issue(1, 5'd7, 5'd1, 1, 1, 5'd6, 1, 0, 0);
    chk("dist2_forwardB", 32'(bus.forwardB), 1);
    chk("dist2_forwardA", 32'(bus.forwardA), 0);

    // Two producers of X1 at distance 1 and 2
    issue(1, 5'd2, 5'd3, 1, 1, 5'd1, 1, 0, 0);
    issue(1, 5'd12, 5'd13, 1, 1, 5'd1, 1, 0, 0);
    issue(1, 5'd1, 5'd15, 1, 1, 5'd14, 1, 0, 0);
    chk("priority_forwardA", 32'(bus.forwardA), 2);

    // LDUR X2,[X0] ; ADD X3,X2,X2 (stalls once, then retried)
    issue(1, 5'd0, 5'd2, 1, 0, 5'd2, 1, 1, 0);
    issue(1, 5'd2, 5'd2, 1, 1, 5'd3, 1, 0, 0);
    chk("loaduse_stall", 32'(last_stall), 1);
    chk("loaduse_bubble", 32'(bus.ex_tag), 0);
    chk("loaduse_count", 32'(bus.stall_count), 1);
    issue(1, 5'd2, 5'd2, 1, 1, 5'd3, 1, 0, 0);
    chk("loaduse_release", 32'(last_stall), 0);
    chk("loaduse_forwardA", 32'(bus.forwardA), 1);
    chk("loaduse_forwardB", 32'(bus.forwardB), 1);
    chk("loaduse_count_hold", 32'(bus.stall_count), 1);

    // Producer writes X31
    issue(1, 5'd1, 5'd2, 1, 1, 5'd31, 1, 0, 0);
    issue(1, 5'd31, 5'd31, 1, 1, 5'd5, 1, 0, 0);
    chk("xzr_forwardA", 32'(bus.forwardA), 0);
    chk("xzr_forwardB", 32'(bus.forwardB), 0);

    // Immediate form: B path does not read X1
    issue(1, 5'd2, 5'd3, 1, 1, 5'd1, 1, 0, 0);
    issue(1, 5'd8, 5'd1, 1, 0, 5'd7, 1, 0, 0);
    chk("imm_forwardB", 32'(bus.forwardB), 0);
    chk("imm_forwardA", 32'(bus.forwardA), 0);

    // Flush during a load-use hazard
    issue(1, 5'd0, 5'd2, 1, 0, 5'd2, 1, 1, 0);
    issue(1, 5'd2, 5'd2, 1, 1, 5'd3, 1, 0, 1);
    chk("flush_stall", 32'(last_stall), 0);
    chk("flush_bubble", 32'(bus.ex_tag), 0);
    chk("flush_forwardA", 32'(bus.forwardA), 0);

    // Reset asserted in the middle of a stall cycle
    issue(1, 5'd2, 5'd3, 1, 1, 5'd1, 1, 0, 0);
    issue(1, 5'd1, 5'd2, 1, 0, 5'd2, 1, 1, 0);
    chk("pre_reset_forwardA", 32'(bus.forwardA), 2);
    set_id(1, 5'd2, 5'd2, 1, 1, 5'd3, 1, 0, 0);
    #2;
    chk("pre_reset_stall", 32'(bus.stall), 1);
    #1 reset = 1'b1;
    #1;
    chk("async_reset_stall", 32'(bus.stall), 0);
    chk("async_reset_forwardA", 32'(bus.forwardA), 0);
    chk("async_reset_forwardB", 32'(bus.forwardB), 0);
    chk("async_reset_count", 32'(bus.stall_count), 0);
    chk("async_reset_ex_tag", 32'(bus.ex_tag), 0);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Dependent pair after reset
    issue(1, 5'd2, 5'd3, 1, 1, 5'd1, 1, 0, 0);
    issue(1, 5'd1, 5'd5, 1, 1, 5'd4, 1, 0, 0);
    chk("post_reset_forwardA", 32'(bus.forwardA), 2);
    chk("post_reset_forwardB", 32'(bus.forwardB), 0);

    repeat (3) issue(0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
